// File: rtl/vga_text_pkg.sv
// Shared definitions for the VGA text-line path.
//   - Font-ROM character codes used when building a line.
//   - Operator encoding carried on the op input.
//   - State enumeration of the expression sequencer.
//   - digit_char(): maps a value 0..9 to its font-ROM digit code.
package vga_text_pkg;

   localparam logic [5:0] CH_SPACE  = 6'o40;
   localparam logic [5:0] CH_MINUS  = 6'o55;
   localparam logic [5:0] CH_PLUS   = 6'o53;
   localparam logic [5:0] CH_STAR   = 6'o52;
   localparam logic [5:0] CH_EQ     = 6'o75;
   localparam logic [5:0] CH_QMARK  = 6'o77;
   localparam logic [5:0] CH_DIGIT0 = 6'o60;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_BAD = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_CONVERT,
      ST_WRITE,
      ST_COMMIT
   } state_e;

   function automatic logic [5:0] digit_char(input logic [3:0] d);
      return CH_DIGIT0 + {2'b00, d};
   endfunction

endpackage

// File: rtl/vga_expr_sequencer_dec_split.sv
// dec_split: splits a 7-bit magnitude (0..64) into decimal tens and ones
// by repeated subtraction of 10, one step per cycle.
//   clk, rst   clock and asynchronous active-high reset
//   start      load mag and begin converting (1-cycle pulse)
//   mag        magnitude to convert
//   tens       tens digit (0..6), valid when done
//   ones       ones digit (0..9), valid when done
//   done       high in the last converting cycle (remainder below 10);
//              tens/ones are final in that cycle and held afterwards
module dec_split (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] mag,
   output logic [2:0] tens,
   output logic [3:0] ones,
   output logic       done
);

   logic [6:0] rem;
   logic       active;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem    <= '0;
         tens   <= '0;
         active <= 1'b0;
      end else if (start) begin
         rem    <= mag;
         tens   <= '0;
         active <= 1'b1;
      end else if (active) begin
         if (rem >= 7'd10) begin
            rem  <= rem - 7'd10;
            tens <= tens + 3'd1;
         end else begin
            active <= 1'b0;
         end
      end
   end

   // The step that finds rem below 10 is also the finishing step, so the
   // conversion takes tens+1 cycles.
   assign done = active && (rem < 7'd10);
   assign ones = rem[3:0];

endmodule

// File: rtl/vga_expr_sequencer.sv
// vga_expr_sequencer: once per frame, snapshots a, b, op, evaluates the
// signed expression and builds the 9-character text line
// "<sa><|a|><op><sb><|b|>=<sr><tens><ones>" in a back buffer, then commits
// it to the front buffer in a single edge so the display never sees a
// partial line.
//   CLOCK_50    clock
//   ar          asynchronous active-high reset
//   frame_tick  1-cycle start pulse (vertical blanking)
//   a, b        4-bit two's-complement operands
//   op          00 add, 01 sub, 10 mul, 11 invalid
//   rd_idx      character column read by the VGA driver
//   rd_char     front-buffer code at rd_idx (space beyond the line)
//   busy        high from CAPTURE through COMMIT
//   done        1-cycle pulse in COMMIT
//   valid       sticky after the first COMMIT
//   overrun     frame_tick seen while busy (tick is ignored)
module vga_expr_sequencer
   import vga_text_pkg::*;
#(
   parameter int NCHAR = 9,
   parameter int RES_W = 9
) (
   input  logic       CLOCK_50,
   input  logic       ar,
   input  logic       frame_tick,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [1:0] op,
   input  logic [3:0] rd_idx,
   output logic [5:0] rd_char,
   output logic       busy,
   output logic       done,
   output logic       valid,
   output logic       overrun
);

   localparam logic [3:0] NCHAR_W  = 4'(NCHAR);
   localparam logic [3:0] LAST_IDX = 4'(NCHAR - 1);

   state_e                  state, state_n;
   logic signed [3:0]       a_q, b_q;
   op_e                     op_q;
   logic                    sign_q;
   logic [3:0]              widx;
   logic [5:0]              back  [16];
   logic [5:0]              front [16];
   logic signed [RES_W-1:0] res;
   logic [6:0]              mag;
   logic [3:0]              a_abs, b_abs;
   logic [5:0]              wchar;
   logic                    conv_done;
   logic [2:0]              tens;
   logic [3:0]              ones;

   dec_split u_dec (
      .clk   (CLOCK_50),
      .rst   (ar),
      .start (state == ST_CAPTURE),
      .mag   (mag),
      .tens  (tens),
      .ones  (ones),
      .done  (conv_done)
   );

   always_ff @(posedge CLOCK_50 or posedge ar) begin
      if (ar) state <= ST_IDLE;
      else    state <= state_n;
   end

   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:    if (frame_tick) state_n = ST_CAPTURE;
         ST_CAPTURE: state_n = ST_CONVERT;
         ST_CONVERT: if (conv_done) state_n = ST_WRITE;
         ST_WRITE:   if (widx == LAST_IDX) state_n = ST_COMMIT;
         ST_COMMIT:  state_n = ST_IDLE;
         default:    state_n = ST_IDLE;
      endcase
   end

   assign busy    = (state != ST_IDLE);
   assign done    = (state == ST_COMMIT);
   assign overrun = frame_tick && busy;

   // Size casts of the signed snapshot sign-extend; the 9-bit product
   // holds the full -56..+64 range of 4x4 signed multiplication.
   always_comb begin
      res = '0;
      case (op_q)
         OP_ADD:  res = RES_W'(a_q) + RES_W'(b_q);
         OP_SUB:  res = RES_W'(a_q) - RES_W'(b_q);
         OP_MUL:  res = RES_W'(a_q) * RES_W'(b_q);
         default: res = '0;
      endcase
      mag = res[RES_W-1] ? 7'(-res) : 7'(res);
   end

   // Negating -8 wraps to 4'b1000, which read unsigned is the wanted 8.
   assign a_abs = a_q[3] ? 4'(-a_q) : 4'(a_q);
   assign b_abs = b_q[3] ? 4'(-b_q) : 4'(b_q);

   always_comb begin
      wchar = CH_SPACE;
      case (widx)
         4'd0: wchar = a_q[3] ? CH_MINUS : CH_SPACE;
         4'd1: wchar = digit_char(a_abs);
         4'd2: begin
            case (op_q)
               OP_ADD:  wchar = CH_PLUS;
               OP_SUB:  wchar = CH_MINUS;
               OP_MUL:  wchar = CH_STAR;
               default: wchar = CH_QMARK;
            endcase
         end
         4'd3: wchar = b_q[3] ? CH_MINUS : CH_SPACE;
         4'd4: wchar = digit_char(b_abs);
         4'd5: wchar = CH_EQ;
         4'd6: wchar = (op_q == OP_BAD) ? CH_QMARK : (sign_q ? CH_MINUS : CH_SPACE);
         4'd7: wchar = (op_q == OP_BAD) ? CH_QMARK :
                       ((tens == 3'd0) ? CH_SPACE : digit_char({1'b0, tens}));
         4'd8: wchar = (op_q == OP_BAD) ? CH_QMARK : digit_char(ones);
         default: wchar = CH_SPACE;
      endcase
   end

   // NOTE: the line buffers are flop arrays, not RAM, and are reset so the
   // display shows blanks immediately after (or during) reset.
   always_ff @(posedge CLOCK_50 or posedge ar) begin
      if (ar) begin
         for (int i = 0; i < 16; i++) begin
            back[i]  <= CH_SPACE;
            front[i] <= CH_SPACE;
         end
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= OP_ADD;
         sign_q <= 1'b0;
         widx   <= '0;
         valid  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // Snapshot only from IDLE: ticks while busy never disturb it.
               if (frame_tick) begin
                  a_q  <= a;
                  b_q  <= b;
                  op_q <= op_e'(op);
               end
            end
            ST_CAPTURE: begin
               sign_q <= res[RES_W-1];
               widx   <= '0;
            end
            ST_WRITE: begin
               back[widx] <= wchar;
               widx       <= widx + 4'd1;
            end
            ST_COMMIT: begin
               front <= back;
               valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign rd_char = (rd_idx < NCHAR_W) ? front[rd_idx] : CH_SPACE;

endmodule

// File: tb/tb_vga_expr_sequencer.sv
// Directed bench for vga_expr_sequencer: reset state, several expressions,
// latency, overrun, reset in mid-operation and out-of-line reads.
module tb_vga_expr_sequencer;

   logic       CLOCK_50   = 1'b0;
   logic       ar         = 1'b1;
   logic       frame_tick = 1'b0;
   logic [3:0] a          = '0;
   logic [3:0] b          = '0;
   logic [1:0] op         = '0;
   logic [3:0] rd_idx     = '0;
   logic [5:0] rd_char;
   logic       busy, done, valid, overrun;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;

   vga_expr_sequencer dut (
      .CLOCK_50   (CLOCK_50),
      .ar         (ar),
      .frame_tick (frame_tick),
      .a          (a),
      .b          (b),
      .op         (op),
      .rd_idx     (rd_idx),
      .rd_char    (rd_char),
      .busy       (busy),
      .done       (done),
      .valid      (valid),
      .overrun    (overrun)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Font-ROM code of a printable character of the line.
   function automatic logic [5:0] code_of(input byte c);
      case (c)
         "-":     return 6'o55;
         "+":     return 6'o53;
         "*":     return 6'o52;
         "=":     return 6'o75;
         "?":     return 6'o77;
         " ":     return 6'o40;
         default: return 6'o60 + 6'(c - "0");
      endcase
   endfunction

   // Reads all 16 columns; columns 9..15 must always be spaces.
   task automatic check_line(input string tag, input string s);
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         #1;
         check($sformatf("%s[%0d]", tag, i), {26'd0, rd_char},
               (i < 9) ? {26'd0, code_of(s[i])} : 32'o40);
      end
   endtask

   task automatic fire(input logic [3:0] ta, input logic [3:0] tb, input logic [1:0] top);
      @(negedge CLOCK_50);
      a          = ta;
      b          = tb;
      op         = top;
      frame_tick = 1'b1;
      @(negedge CLOCK_50);
      frame_tick = 1'b0;
   endtask

   // Counts negedges since the tick; bounded so a dead DUT cannot hang the run.
   task automatic wait_done(input int start, output int cycles);
      cycles = start;
      while (done !== 1'b1 && cycles < 200) begin
         @(negedge CLOCK_50);
         cycles++;
      end
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge CLOCK_50);
      check("rst_busy", busy, 1'b0);
      check("rst_valid", valid, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      ar = 1'b0;
      check_line("rst_line", "         ");

      // 3 + -2 = 1, done 12 cycles after the tick
      fire(4'd3, 4'hE, 2'b00);
      check("t2_busy_capture", busy, 1'b1);
      wait_done(1, cyc);
      check("t2_latency", cyc, 12);
      @(negedge CLOCK_50);
      check("t2_done_pulse", done, 1'b0);
      check("t2_valid", valid, 1'b1);
      check("t2_busy_idle", busy, 1'b0);
      check_line("t2_line", " 3+-2=  1");

      // Reset mid-frame clears both buffers and valid
      fire(4'd5, 4'd5, 2'b00);
      repeat (2) @(negedge CLOCK_50);
      ar = 1'b1;
      #1;
      check("t1_busy", busy, 1'b0);
      check("t1_valid", valid, 1'b0);
      check_line("t1_line", "         ");
      @(negedge CLOCK_50);
      ar = 1'b0;

      // -8 * -8 = 64, CONVERT takes 7 cycles -> 1+7+9+1
      fire(4'h8, 4'h8, 2'b10);
      wait_done(1, cyc);
      check("t3_latency", cyc, 18);
      @(negedge CLOCK_50);
      check_line("t3_line", "-8*-8= 64");

      // -8 - 7 = -15, plus a tick landing in COMMIT
      fire(4'h8, 4'd7, 2'b01);
      wait_done(1, cyc);
      check("t4_latency", cyc, 13);
      frame_tick = 1'b1;
      #1;
      check("t4_overrun_commit", overrun, 1'b1);
      @(negedge CLOCK_50);
      frame_tick = 1'b0;
      #1;
      check("t4_tick_ignored", busy, 1'b0);
      check_line("t4_line", "-8- 7=-15");

      // Invalid op, and a second tick 3 cycles later with new operands
      fire(4'd3, 4'd2, 2'b11);
      repeat (2) @(negedge CLOCK_50);
      a          = 4'd5;
      b          = 4'd5;
      op         = 2'b00;
      frame_tick = 1'b1;
      #1;
      check("t5_overrun", overrun, 1'b1);
      @(negedge CLOCK_50);
      frame_tick = 1'b0;
      #1;
      check("t5_overrun_pulse", overrun, 1'b0);
      wait_done(4, cyc);
      check("t5_latency", cyc, 12);
      @(negedge CLOCK_50);
      check_line("t5_line", " 3? 2=???");

      // Reset during WRITE, then a zero result completes normally
      fire(4'd1, 4'd1, 2'b00);
      repeat (4) @(negedge CLOCK_50);
      check("t6_busy_write", busy, 1'b1);
      ar = 1'b1;
      #1;
      check("t6_busy_rst", busy, 1'b0);
      check("t6_valid_rst", valid, 1'b0);
      check_line("t6_rst_line", "         ");
      @(negedge CLOCK_50);
      ar = 1'b0;
      fire(4'd3, 4'hD, 2'b00);
      wait_done(1, cyc);
      check("t6_latency", cyc, 12);
      @(negedge CLOCK_50);
      check("t6_valid", valid, 1'b1);
      check_line("t6_line", " 3+-3=  0");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
